// File: rtl/pkt_fork_pkg.sv
// Shared types for the packet fork.
// Output registering is selected by PKT_FORK_OUT_REG_EN.
package pkt_fork_pkg;

  localparam int NUM_OUT_MAX  = 16;
  localparam int FLIT_DATA_W  = 512;
  localparam int FLIT_EMPTY_W = 6;

  typedef enum logic [1:0] {
    IDLE,
    FWD,
    DROP
  } fork_state_t;

  typedef struct packed {
    logic [FLIT_DATA_W-1:0]  data;
    logic                    sop;
    logic                    eop;
    logic [FLIT_EMPTY_W-1:0] empty;
  } flit_t;

endpackage

// File: rtl/pkt_fork_skid.sv
// Two-entry valid/ready skid buffer carrying a flit plus a one-hot
// destination vector; used when PKT_FORK_OUT_REG_EN is defined.
module pkt_fork_skid #(
  parameter int W  = 520,
  parameter int NV = 4
) (
  input  logic          Clk,
  input  logic          Rst_n,
  input  logic [W-1:0]  in_data,
  input  logic [NV-1:0] in_vec,
  output logic          in_ready,
  output logic [W-1:0]  out_data,
  output logic [NV-1:0] out_vec,
  input  logic [NV-1:0] out_ready
);

  logic [W+NV-1:0] mem [2];
  logic [NV-1:0]   vec_raw;
  logic            wr_ptr;
  logic            rd_ptr;
  logic [1:0]      cnt;
  logic            push;
  logic            pop;

  // Ready comes from occupancy only, never from out_ready.
  assign in_ready = (cnt != 2'd2);
  assign push     = in_ready & (|in_vec);

  assign {out_data, vec_raw} = mem[rd_ptr];
  assign out_vec = (cnt != 2'd0) ? vec_raw : '0;
  assign pop     = |(out_vec & out_ready);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {in_data, in_vec};
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      cnt <= cnt + 2'(push) - 2'(pop);
    end
  end

endmodule

// File: rtl/pkt_fork_n_service.sv
// N-way packet fork steered by a selector stream, with statistics.
// PKT_FORK_OUT_REG_EN adds a registered skid stage on the outputs.
module pkt_fork_n_service
  import pkt_fork_pkg::*;
#(
  parameter int DATA_W  = 512,
  parameter int EMPTY_W = 6,
  parameter int NUM_OUT = 4,
  parameter int SEL_W   = 4
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic [DATA_W-1:0]     in_data,
  input  logic                  in_sop,
  input  logic                  in_eop,
  input  logic [EMPTY_W-1:0]    in_empty,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [SEL_W-1:0]      sel_data,
  input  logic                  sel_valid,
  output logic                  sel_ready,
  output logic [DATA_W-1:0]     out_data,
  output logic                  out_sop,
  output logic                  out_eop,
  output logic [EMPTY_W-1:0]    out_empty,
  output logic [NUM_OUT-1:0]    out_valid,
  input  logic [NUM_OUT-1:0]    out_ready,
  output logic [NUM_OUT*32-1:0] stats_out_pkt,
  output logic [31:0]           stats_drop_pkt,
  output logic [31:0]           stats_err_flit
);

  fork_state_t        state;
  logic [NUM_OUT-1:0] dest_oh;
  logic [NUM_OUT-1:0] sel_oh;
  logic [NUM_OUT-1:0] dn_valid;
  logic [NUM_OUT-1:0] dn_ready;
  logic [NUM_OUT-1:0] pkt_inc;
  logic               sel_hit;
  logic               rdy;
  logic               pop;
  logic               acc;
  logic               drop_inc;
  logic               err_inc;
  logic [31:0]        pkt_cnt [NUM_OUT];
  logic [31:0]        drop_cnt;
  logic [31:0]        err_cnt;

  always_comb begin
    sel_oh = '0;
    for (int i = 0; i < NUM_OUT; i++)
      if (sel_data == SEL_W'(i)) sel_oh[i] = 1'b1;
  end

  assign sel_hit = |sel_oh;

  always_comb begin
    dn_valid = '0;
    rdy      = 1'b0;
    pop      = 1'b0;
    acc      = 1'b0;
    pkt_inc  = '0;
    drop_inc = 1'b0;
    err_inc  = 1'b0;
    unique case (state)
      IDLE: begin
        if (in_valid && !in_sop) begin
          rdy     = 1'b1;
          err_inc = 1'b1;
        end else if (in_valid && sel_valid) begin
          dn_valid = sel_oh;
          rdy      = sel_hit ? |(sel_oh & dn_ready) : 1'b1;
          pop      = rdy;
          if (rdy && in_eop) begin
            pkt_inc  = sel_oh;
            drop_inc = !sel_hit;
          end
        end
      end
      FWD: begin
        dn_valid = in_valid ? dest_oh : '0;
        rdy      = |(dest_oh & dn_ready);
        acc      = in_valid & rdy;
        err_inc  = acc & in_sop;
        pkt_inc  = (acc & in_eop) ? dest_oh : '0;
      end
      DROP: begin
        rdy      = 1'b1;
        err_inc  = in_valid & in_sop;
        drop_inc = in_valid & in_eop;
      end
      default: ;
    endcase
    acc = in_valid & rdy;
  end

  assign in_ready  = rdy & Rst_n;
  assign sel_ready = pop & Rst_n;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state    <= IDLE;
      dest_oh  <= '0;
      drop_cnt <= '0;
      err_cnt  <= '0;
      for (int i = 0; i < NUM_OUT; i++) pkt_cnt[i] <= '0;
    end else begin
      if (acc) begin
        unique case (state)
          IDLE: if (in_sop && !in_eop) begin
            state   <= sel_hit ? FWD : DROP;
            dest_oh <= sel_oh;
          end
          FWD, DROP: if (in_eop) state <= IDLE;
          default: state <= IDLE;
        endcase
      end
      for (int i = 0; i < NUM_OUT; i++)
        if (pkt_inc[i]) pkt_cnt[i] <= pkt_cnt[i] + 32'd1;
      if (drop_inc) drop_cnt <= drop_cnt + 32'd1;
      if (err_inc) err_cnt <= err_cnt + 32'd1;
    end
  end

  for (genvar g = 0; g < NUM_OUT; g++) begin : g_stats
    assign stats_out_pkt[32*g +: 32] = pkt_cnt[g];
  end

  assign stats_drop_pkt = drop_cnt;
  assign stats_err_flit = err_cnt;

`ifdef PKT_FORK_OUT_REG_EN
  localparam int FW = DATA_W + EMPTY_W + 2;

  logic               skid_rdy;
  logic [FW-1:0]      skid_q;
  logic [NUM_OUT-1:0] skid_v;

  assign dn_ready = {NUM_OUT{skid_rdy}};

  pkt_fork_skid #(
    .W  (FW),
    .NV (NUM_OUT)
  ) u_skid (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .in_data   ({in_data, in_sop, in_eop, in_empty}),
    .in_vec    (dn_valid),
    .in_ready  (skid_rdy),
    .out_data  (skid_q),
    .out_vec   (skid_v),
    .out_ready (out_ready)
  );

  assign {out_data, out_sop, out_eop, out_empty} = skid_q;
  assign out_valid = skid_v & {NUM_OUT{Rst_n}};
`else
  assign dn_ready  = out_ready;
  assign out_data  = in_data;
  assign out_sop   = in_sop;
  assign out_eop   = in_eop;
  assign out_empty = in_empty;
  assign out_valid = dn_valid & {NUM_OUT{Rst_n}};
`endif

endmodule

// File: tb/tb_pkt_fork_n_service.sv
// Self-checking bench for pkt_fork_n_service: vector table, directed
// sequences and randomized traffic against a packet-level scoreboard.
module tb_pkt_fork_n_service;

  localparam int DATA_W  = 512;
  localparam int EMPTY_W = 6;
  localparam int NUM_OUT = 4;
  localparam int SEL_W   = 4;

  logic                  Clk;
  logic                  Rst_n;
  logic [DATA_W-1:0]     in_data;
  logic                  in_sop;
  logic                  in_eop;
  logic [EMPTY_W-1:0]    in_empty;
  logic                  in_valid;
  logic                  in_ready;
  logic [SEL_W-1:0]      sel_data;
  logic                  sel_valid;
  logic                  sel_ready;
  logic [DATA_W-1:0]     out_data;
  logic                  out_sop;
  logic                  out_eop;
  logic [EMPTY_W-1:0]    out_empty;
  logic [NUM_OUT-1:0]    out_valid;
  logic [NUM_OUT-1:0]    out_ready;
  logic [NUM_OUT*32-1:0] stats_out_pkt;
  logic [31:0]           stats_drop_pkt;
  logic [31:0]           stats_err_flit;

  pkt_fork_n_service #(
    .DATA_W  (DATA_W),
    .EMPTY_W (EMPTY_W),
    .NUM_OUT (NUM_OUT),
    .SEL_W   (SEL_W)
  ) dut (
    .Clk            (Clk),
    .Rst_n          (Rst_n),
    .in_data        (in_data),
    .in_sop         (in_sop),
    .in_eop         (in_eop),
    .in_empty       (in_empty),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .sel_data       (sel_data),
    .sel_valid      (sel_valid),
    .sel_ready      (sel_ready),
    .out_data       (out_data),
    .out_sop        (out_sop),
    .out_eop        (out_eop),
    .out_empty      (out_empty),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .stats_out_pkt  (stats_out_pkt),
    .stats_drop_pkt (stats_drop_pkt),
    .stats_err_flit (stats_err_flit)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [DATA_W-1:0]  d;
    logic               s;
    logic               e;
    logic [EMPTY_W-1:0] em;
  } fl_t;

  typedef struct {
    bit       v;
    bit       s;
    bit       e;
    bit       sv;
    logic [3:0] sel;
    logic [3:0] ordy;
    bit       xir;
    bit       xsr;
    logic [3:0] xov;
  } vec_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  fl_t  expq [NUM_OUT][$];
  int   exp_pkt [NUM_OUT];
  int   exp_drop = 0;
  int   exp_err = 0;
  bit   sb_off = 1'b0;
  int   rmode = 0;
  int   pidx = 0;
  logic [3:0] pat [8];
  fl_t  mon_f;

  task automatic chk(input string name, input logic [DATA_W-1:0] act,
                     input logic [DATA_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] rnd512();
    logic [DATA_W-1:0] r;
    for (int i = 0; i < DATA_W / 32; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  always @(posedge Clk) begin
    #2;
    case (rmode)
      0: out_ready = '1;
      1: out_ready = 4'($urandom);
      2: begin
        out_ready = (pidx < 8) ? pat[pidx] : 4'hF;
        pidx++;
      end
      default: ;
    endcase
  end

  always @(negedge Clk) begin
    if (Rst_n && !sb_off) begin
      if (out_valid != '0)
        chk("onehot", DATA_W'($onehot(out_valid)), 1);
      for (int i = 0; i < NUM_OUT; i++) begin
        if (out_valid[i] && out_ready[i]) begin
          if (expq[i].size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL stray_flit out%0d: got data %0h required none",
                     i, out_data[31:0]);
          end else begin
            mon_f = expq[i].pop_front();
            chk($sformatf("data_out%0d", i), out_data, mon_f.d);
            chk($sformatf("flags_out%0d", i),
                DATA_W'({out_sop, out_eop, out_empty}),
                DATA_W'({mon_f.s, mon_f.e, mon_f.em}));
          end
        end
      end
    end
  end

  task automatic model_clear();
    for (int i = 0; i < NUM_OUT; i++) begin
      expq[i].delete();
      exp_pkt[i] = 0;
    end
    exp_drop = 0;
    exp_err  = 0;
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    sel_valid = 1'b0;
    Rst_n     = 1'b0;
    tick();
    tick();
    @(negedge Clk);
    Rst_n = 1'b1;
    model_clear();
    tick();
  endtask

  task automatic send(input int sel, input int len, input int maxgap,
                      input bit track, output int cyc);
    int  g;
    bit  ok;
    fl_t fl;
    cyc = 0;
    for (int f = 0; f < len; f++) begin
      g = (maxgap > 0) ? $urandom_range(maxgap, 0) : 0;
      for (int k = 0; k < g; k++) begin
        in_valid  = 1'b0;
        sel_valid = 1'b0;
        tick();
        cyc++;
      end
      fl.d  = rnd512();
      fl.s  = (f == 0);
      fl.e  = (f == len - 1);
      fl.em = 6'($urandom);
      in_valid  = 1'b1;
      in_data   = fl.d;
      in_sop    = fl.s;
      in_eop    = fl.e;
      in_empty  = fl.em;
      sel_valid = (f == 0);
      sel_data  = SEL_W'(sel);
      if (sel < NUM_OUT) expq[sel].push_back(fl);
      ok = 1'b0;
      for (int k = 0; k < 1000 && !ok; k++) begin
        @(negedge Clk);
`ifndef PKT_FORK_OUT_REG_EN
        if (track) chk("ready_track", DATA_W'(in_ready), DATA_W'(out_ready[1]));
`endif
        if (in_ready) begin
          ok = 1'b1;
          if (f == 0) chk("sel_pop", DATA_W'(sel_ready), 1);
        end
        tick();
        cyc++;
      end
      if (!ok) begin
        n_cmp++;
        n_bad++;
        $display("FAIL flit_timeout: got no accept required accept sel %0d", sel);
      end
      if (ok && fl.e) begin
        if (sel < NUM_OUT) exp_pkt[sel]++;
        else exp_drop++;
      end
    end
    in_valid  = 1'b0;
    sel_valid = 1'b0;
  endtask

  task automatic drain();
    rmode = 0;
    repeat (8) tick();
  endtask

  task automatic check_counters(input string tag);
    for (int i = 0; i < NUM_OUT; i++) begin
      chk($sformatf("%s_pkt%0d", tag, i), DATA_W'(stats_out_pkt[32*i +: 32]),
          DATA_W'(exp_pkt[i]));
      chk($sformatf("%s_q%0d", tag, i), DATA_W'(expq[i].size()), 0);
    end
    chk({tag, "_drop"}, DATA_W'(stats_drop_pkt), DATA_W'(exp_drop));
    chk({tag, "_err"}, DATA_W'(stats_err_flit), DATA_W'(exp_err));
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish required finish");
    $fatal(1);
  end

  initial begin
    int   c;
    int   c2;
    int   tot;
    vec_t tbl [14];

    model_clear();
    Rst_n     = 1'b0;
    rmode     = 0;
    out_ready = '1;
    in_data   = '0;
    in_empty  = '0;
    sel_data  = 4'd1;
    in_valid  = 1'b1;
    in_sop    = 1'b1;
    in_eop    = 1'b0;
    sel_valid = 1'b1;
    #3;
    chk("rst_in_ready", DATA_W'(in_ready), 0);
    chk("rst_sel_ready", DATA_W'(sel_ready), 0);
    chk("rst_out_valid", DATA_W'(out_valid), 0);
    chk("rst_stats", DATA_W'({stats_out_pkt, stats_drop_pkt, stats_err_flit}), 0);
    do_reset();

`ifndef PKT_FORK_OUT_REG_EN
    tbl[0]  = '{0, 0, 0, 0, 4'd0, 4'hF, 0, 0, 4'h0};
    tbl[1]  = '{1, 1, 0, 0, 4'd0, 4'hF, 0, 0, 4'h0};
    tbl[2]  = '{1, 0, 0, 1, 4'd2, 4'hF, 1, 0, 4'h0};
    tbl[3]  = '{1, 1, 0, 1, 4'd1, 4'h0, 0, 0, 4'h2};
    tbl[4]  = '{1, 1, 0, 1, 4'd1, 4'h2, 1, 1, 4'h2};
    tbl[5]  = '{1, 0, 0, 0, 4'd0, 4'h0, 0, 0, 4'h2};
    tbl[6]  = '{1, 1, 0, 1, 4'd3, 4'hF, 1, 0, 4'h2};
    tbl[7]  = '{1, 0, 1, 0, 4'd0, 4'h2, 1, 0, 4'h2};
    tbl[8]  = '{1, 1, 1, 1, 4'd9, 4'hF, 1, 1, 4'h0};
    tbl[9]  = '{1, 1, 0, 1, 4'd7, 4'h0, 1, 1, 4'h0};
    tbl[10] = '{0, 0, 0, 1, 4'd0, 4'hF, 1, 0, 4'h0};
    tbl[11] = '{1, 0, 1, 0, 4'd0, 4'h0, 1, 0, 4'h0};
    tbl[12] = '{1, 1, 1, 1, 4'd2, 4'h4, 1, 1, 4'h4};
    tbl[13] = '{0, 0, 0, 1, 4'd3, 4'hF, 0, 0, 4'h0};
    sb_off = 1'b1;
    rmode  = 3;
    for (int i = 0; i < 14; i++) begin
      in_valid  = tbl[i].v;
      in_sop    = tbl[i].s;
      in_eop    = tbl[i].e;
      sel_valid = tbl[i].sv;
      sel_data  = tbl[i].sel;
      out_ready = tbl[i].ordy;
      in_data   = rnd512();
      @(negedge Clk);
      chk($sformatf("vec%0d", i), DATA_W'({in_ready, sel_ready, out_valid}),
          DATA_W'({tbl[i].xir, tbl[i].xsr, tbl[i].xov}));
      if (tbl[i].xov != 4'h0) chk($sformatf("vec%0d_data", i), out_data, in_data);
      tick();
    end
    in_valid  = 1'b0;
    sel_valid = 1'b0;
    chk("tbl_stats_pkt", DATA_W'(stats_out_pkt), DATA_W'({32'd0, 32'd1, 32'd1, 32'd0}));
    chk("tbl_stats_drop", DATA_W'(stats_drop_pkt), 2);
    chk("tbl_stats_err", DATA_W'(stats_err_flit), 2);
    sb_off = 1'b0;
    rmode  = 0;
    do_reset();
`endif

    tot = 0;
    for (int s = 0; s < NUM_OUT; s++) begin
      send(s, 3, 0, 0, c);
      tot += c;
    end
    chk("t1_cycles", DATA_W'(tot), 12);
    drain();
    check_counters("t1");

    send(7, 2, 0, 0, c);
    send(2, 1, 0, 0, c2);
    chk("t2_cycles", DATA_W'(c + c2), 3);
    drain();
    check_counters("t2");

    pat[0] = 4'hF;
    pat[1] = 4'hD;
    pat[2] = 4'hD;
    for (int i = 3; i < 8; i++) pat[i] = 4'hF;
    pidx  = 0;
    rmode = 2;
    send(1, 4, 0, 1, c);
    chk("t3_cycles", DATA_W'(c), 6);
    drain();
    check_counters("t3");

    in_valid  = 1'b1;
    in_sop    = 1'b0;
    in_eop    = 1'b0;
    sel_valid = 1'b0;
    in_data   = rnd512();
    @(negedge Clk);
    chk("t4_err_ready", DATA_W'(in_ready), 1);
    tick();
    exp_err++;
    in_sop = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge Clk);
      chk("t4_stall", DATA_W'({in_ready, sel_ready}), 0);
      tick();
    end
    send(2, 2, 0, 0, c);
    drain();
    check_counters("t4");

    rmode = 1;
    for (int p = 0; p < 60; p++)
      send($urandom_range(9, 0), $urandom_range(4, 1), 2, 0, c);
    drain();
    check_counters("rnd");

    sb_off    = 1'b1;
    in_valid  = 1'b1;
    in_sop    = 1'b1;
    in_eop    = 1'b0;
    sel_valid = 1'b1;
    sel_data  = 4'd3;
    tick();
    in_sop    = 1'b0;
    sel_valid = 1'b0;
    tick();
    #2;
    Rst_n = 1'b0;
    #1;
    chk("t5_out_valid", DATA_W'(out_valid), 0);
    chk("t5_in_ready", DATA_W'(in_ready), 0);
    chk("t5_stats", DATA_W'({stats_out_pkt, stats_drop_pkt, stats_err_flit}), 0);
    in_valid = 1'b0;
    @(posedge Clk);
    #3;
    Rst_n = 1'b1;
    model_clear();
    sb_off = 1'b0;
    tick();
    send(3, 2, 0, 0, c);
    drain();
    check_counters("t5");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
